// File: rtl/a3_pkg.sv
// Shared types for the a3 scheduler: FU operation codes, FSM states and the default width.
package a3_pkg;

  localparam int W_DEF = 6;

  typedef enum logic [1:0] {
    FU_NOP = 2'd0,
    FU_A1  = 2'd1,
    FU_A2  = 2'd2,
    FU_A0  = 2'd3
  } fu_op_t;

  typedef enum logic [2:0] {
    IDLE,
    S_A1,
    S_A2,
    S_A0,
    S_OUT
  } state_t;

endpackage

// File: rtl/a3_sched_arb.sv
// Two-way round-robin arbiter; the pointer register is owned by the caller.
module rr_arb2
  import a3_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    // On a tie, the requester that did not win last time goes next.
    if (req == 2'b11) gnt_id = ~last_grant;
    else              gnt_id = req[1];
  end

endmodule

// File: rtl/a3_sched.sv
// Time-multiplexes z = a0(a1(x1,y1), a2(x2,y2)) for two requesters onto one shared FU.
module a3_sched
  import a3_pkg::*;
#(
  parameter int W = W_DEF
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in_valid,
  output logic [1:0]          in_ready,
  input  logic signed [W-1:0] in_x1 [2],
  input  logic signed [W-1:0] in_y1 [2],
  input  logic signed [W-1:0] in_x2 [2],
  input  logic signed [W-1:0] in_y2 [2],
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_z,
  output logic                out_id,
  output fu_op_t              fu_op,
  output logic signed [W-1:0] fu_a,
  output logic signed [W-1:0] fu_b,
  input  logic signed [W-1:0] fu_z,
  output logic                busy
);

  state_t state, state_nxt;

  logic signed [W-1:0] x1_r, y1_r, x2_r, y2_r;
  logic signed [W-1:0] z1_r, z2_r;
  logic                last_grant;
  logic                gnt_valid, gnt_id;
  logic                accept;

  rr_arb2 u_arb (
    .req        (in_valid),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    in_ready  = 2'b00;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          in_ready[gnt_id] = 1'b1;
          accept           = 1'b1;
          state_nxt        = S_A1;
        end
      end
      S_A1:    state_nxt = S_A2;
      S_A2:    state_nxt = S_A0;
      S_A0:    state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fu_op = FU_NOP;
    fu_a  = '0;
    fu_b  = '0;
    case (state)
      S_A1: begin
        fu_op = FU_A1;
        fu_a  = x1_r;
        fu_b  = y1_r;
      end
      S_A2: begin
        fu_op = FU_A2;
        fu_a  = x2_r;
        fu_b  = y2_r;
      end
      S_A0: begin
        fu_op = FU_A0;
        fu_a  = z1_r;
        fu_b  = z2_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_z      <= '0;
      out_id     <= 1'b0;
      x1_r       <= '0;
      y1_r       <= '0;
      x2_r       <= '0;
      y2_r       <= '0;
      z1_r       <= '0;
      z2_r       <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            x1_r       <= in_x1[gnt_id];
            y1_r       <= in_y1[gnt_id];
            x2_r       <= in_x2[gnt_id];
            y2_r       <= in_y2[gnt_id];
            out_id     <= gnt_id;
            last_grant <= gnt_id;
          end
        end
        S_A1: z1_r <= fu_z;
        S_A2: z2_r <= fu_z;
        S_A0: begin
          out_z     <= fu_z;
          out_valid <= 1'b1;
        end
        S_OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_a3_sched.sv
// Scoreboard bench for a3_sched with a wrapping 6-bit FU model (A1=a+b, A2=a-b, A0=a+b).
module tb_a3_sched;
  import a3_pkg::*;

  localparam int W = 6;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          in_valid;
  logic [1:0]          in_ready;
  logic signed [W-1:0] in_x1 [2];
  logic signed [W-1:0] in_y1 [2];
  logic signed [W-1:0] in_x2 [2];
  logic signed [W-1:0] in_y2 [2];
  logic                out_valid, out_ready, out_id, busy;
  logic signed [W-1:0] out_z, fu_a, fu_b, fu_z;
  fu_op_t              fu_op;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [W:0] exp_q [$];
  logic [W:0] mon_e;

  always #5 clk = ~clk;

  a3_sched #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_y1(in_y1), .in_x2(in_x2), .in_y2(in_y2),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_id(out_id),
    .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b), .fu_z(fu_z),
    .busy(busy)
  );

  always_comb begin
    fu_z = '0;
    case (fu_op)
      FU_A1, FU_A0: fu_z = fu_a + fu_b;
      FU_A2:        fu_z = fu_a - fu_b;
      default:      fu_z = '0;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_fu(input string tag, input fu_op_t op, input int a, input int b);
    check({tag, "_op"}, int'(fu_op), int'(op));
    check({tag, "_a"}, int'(fu_a), a);
    check({tag, "_b"}, int'(fu_b), b);
  endtask

  task automatic push_exp(input logic id, input int z);
    logic [W-1:0] zz;
    zz = z[W-1:0];
    exp_q.push_back({id, zz});
  endtask

  // Monitor: every output handshake pops one expected {id, z}.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_out_id", int'(out_id), int'(mon_e[W]));
        check("sb_out_z", int'(out_z), int'($signed(mon_e[W-1:0])));
      end
    end
  end

  // Runs one job from IDLE to the first S_OUT cycle, checking every FU step.
  task automatic job(input logic [1:0] vmask, input logic gid,
                     input int x1, input int y1, input int x2, input int y2,
                     input int z1, input int z2, input int z);
    @(posedge clk); #1;
    in_x1[gid] = x1[W-1:0];
    in_y1[gid] = y1[W-1:0];
    in_x2[gid] = x2[W-1:0];
    in_y2[gid] = y2[W-1:0];
    in_valid   = vmask;
    @(negedge clk);
    check("idle_in_ready", int'(in_ready), gid ? 2 : 1);
    check("idle_busy", int'(busy), 0);
    check_fu("idle", FU_NOP, 0, 0);
    push_exp(gid, z);
    @(posedge clk); #1;
    in_valid = 2'b00;
    @(negedge clk);
    check_fu("a1", FU_A1, x1, y1);
    check("a1_in_ready", int'(in_ready), 0);
    check("a1_busy", int'(busy), 1);
    @(negedge clk);
    check_fu("a2", FU_A2, x2, y2);
    check("a2_in_ready", int'(in_ready), 0);
    @(negedge clk);
    check_fu("a0", FU_A0, z1, z2);
    check("a0_out_valid", int'(out_valid), 0);
    @(negedge clk);
    check_fu("out", FU_NOP, 0, 0);
    check("out_valid", int'(out_valid), 1);
    check("out_z", int'(out_z), z);
    check("out_id", int'(out_id), int'(gid));
    check("out_in_ready", int'(in_ready), 0);
    check("out_busy", int'(busy), 1);
  endtask

  task automatic finish_job();
    @(negedge clk);
    check("post_busy", int'(busy), 0);
    check("post_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid  = 2'b00;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_x1[i] = '0; in_y1[i] = '0; in_x2[i] = '0; in_y2[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_z", int'(out_z), 0);
    check("rst_out_id", int'(out_id), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check_fu("rst", FU_NOP, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single job on requester 0
    job(2'b01, 1'b0, 5, 3, 10, 4, 8, 6, 14);
    finish_job();

    // 2: wrap on requester 1
    job(2'b10, 1'b1, 31, 1, 0, 0, -32, 0, -32);
    finish_job();

    // 3: both valid, three back-to-back jobs, grant order 0,1,0
    @(posedge clk); #1;
    in_x1[0] = 6'sd1;  in_y1[0] = 6'sd2;  in_x2[0] = 6'sd3;   in_y2[0] = 6'sd1;
    in_x1[1] = -6'sd5; in_y1[1] = -6'sd6; in_x2[1] = -6'sd20; in_y2[1] = 6'sd15;
    in_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rr_in_ready", int'(in_ready), (k == 1) ? 2 : 1);
      if (k == 1) push_exp(1'b1, 18);
      else        push_exp(1'b0, 5);
      if (k == 2) begin
        @(posedge clk); #1;
        in_valid = 2'b00;
      end
      repeat (4) @(negedge clk);
    end
    finish_job();

    // 4: backpressure holds S_OUT, a pending request is not accepted
    out_ready = 1'b0;
    job(2'b01, 1'b0, 7, -2, -3, 4, 5, -7, -2);
    in_x1[1] = 6'sd1; in_y1[1] = 6'sd1; in_x2[1] = 6'sd1; in_y2[1] = 6'sd1;
    in_valid = 2'b10;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_z", int'(out_z), -2);
      check("bp_out_id", int'(out_id), 0);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_busy", int'(busy), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 2'b00;
    @(negedge clk);
    check("bp_release_valid", int'(out_valid), 1);
    finish_job();

    // 5: reset while in S_A2 discards the job
    @(posedge clk); #1;
    in_x1[0] = 6'sd5; in_y1[0] = 6'sd3; in_x2[0] = 6'sd10; in_y2[0] = 6'sd4;
    in_valid = 2'b01;
    @(posedge clk); #1;
    in_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_fu("rstmid_a2", FU_A2, 10, 4);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_out_valid", int'(out_valid), 0);
    check_fu("rstmid", FU_NOP, 0, 0);
    repeat (5) @(negedge clk);
    check("rstmid_no_out", int'(out_valid), 0);

    // Pointer is back at reset value: requester 0 wins the tie
    job(2'b11, 1'b0, -32, -1, -32, 1, 31, 31, -2);
    finish_job();

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/a3_sched.md
Name: a3_sched

Overview:
- Time-multiplexed controller that computes the a3 function z = a0(a1(x1,y1), a2(x2,y2)) on one shared function unit (FU), not three instances.
- Two requesters submit operand sets through valid/ready handshakes; a round-robin arbiter picks one job.
- The FSM sequences the A1, A2 and A0 steps through the FU and returns the tagged result on a valid/ready output channel.
- Sits between the requesting pipelines and the shared signed 6-bit FU.

Parameters:
- W, 6: signed datapath width of all operands and results.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  2  per-requester job valid; bit i belongs to requester i.
- in_ready  output  2  per-requester accept; at most one bit high per cycle.
- in_x1, in_y1, in_x2, in_y2  input  2 x W  per-requester signed operands, as an unpacked array indexed by requester.
- out_valid  output  1  result valid.
- out_ready  input  1  result accept.
- out_z  output  W  signed result.
- out_id  output  1  index of the requester that owns out_z.
- fu_op  output  2  FU operation select (fu_op_t).
- fu_a, fu_b  output  W  FU operands.
- fu_z  input  W  FU result; combinational, same cycle as fu_op/fu_a/fu_b.
- busy  output  1  high in every state except IDLE.

Behaviour:
- States: IDLE, S_A1, S_A2, S_A0, S_OUT.
- Reset values:
  - state=IDLE; out_valid=0; out_z=0; out_id=0; busy=0.
  - Internal operand and z1/z2 registers = 0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first tie.
- FU outputs are combinational from state:
  - IDLE and S_OUT: fu_op=FU_NOP, fu_a=0, fu_b=0.
  - S_A1: FU_A1, x1, y1. S_A2: FU_A2, x2, y2. S_A0: FU_A0, z1, z2.
- Arbitration (IDLE only):
  - One valid: grant that requester.
  - Both valid: grant !last_grant.
  - in_ready[grant]=1 combinationally; in_ready=0 in all other states.
- Accept edge (IDLE and in_valid[g] and in_ready[g]):
  - Latch the four operands and the id.
  - last_grant<=g; go to S_A1.
- Step captures:
  - S_A1: z1<=fu_z, go to S_A2.
  - S_A2: z2<=fu_z, go to S_A0.
  - S_A0: out_z<=fu_z, out_valid<=1, go to S_OUT.
- S_OUT:
  - Hold out_z, out_id and out_valid stable until out_ready.
  - On out_valid and out_ready: out_valid<=0, go to IDLE.
- Latency and throughput:
  - Accept at edge T gives out_valid high from edge T+3.
  - Minimum 5 cycles per job with out_ready tied high. No overlap of jobs.
- Arithmetic: the controller passes W-bit signed values without width change. Wrapping and saturation are defined by the FU, not here.
- Output backpressure: indefinite out_ready=0 holds S_OUT. Both in_ready bits stay 0 and requester valids are not consumed.
- Requester rules:
  - A requester may drop in_valid without being accepted; nothing is latched.
  - Operands may change while not accepted.
- Reset mid-job: the job is discarded and no output is produced. All registers return to reset values on the next edge.
- rst has priority over every transition.

Decomposition:
- Package a3_pkg contains:
  - Constant W_DEF=6.
  - typedef enum logic [1:0] fu_op_t {FU_NOP=0, FU_A1=1, FU_A2=2, FU_A0=3}.
  - typedef enum state_t for the five FSM states.
- Sub-module rr_arb2 (2-way round-robin).
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt_valid, gnt_id.
  - Purely combinational; the pointer register lives in a3_sched.

Test Plan:
Bench FU model: A1=a+b, A2=a-b, A0=a+b, each wrapped to 6-bit signed.
1. Single job on req0: x1=5, y1=3, x2=10, y2=4, out_ready=1 -> z1=8, z2=6; out_z=14, out_id=0 at accept+3; in_ready low for 5 cycles.
2. Wrap: x1=31, y1=1, x2=0, y2=0 on req1 -> out_z=-32, out_id=1.
3. Both valid for 3 back-to-back jobs -> grant order 0, 1, 0; out_id sequence 0, 1, 0.
4. Backpressure: out_ready=0 for 10 cycles after out_valid -> out_z and out_id stable, in_ready=0, busy=1; release -> one transfer, then IDLE.
5. Reset mid-job (rst asserted in S_A2 for 1 cycle) -> out_valid never asserts for that job; state IDLE; next job accepted normally with req0 priority.
6. Check fu_op sequence NOP, A1, A2, A0, NOP per job, with fu_a/fu_b = 0 when NOP.
